// File: rtl/bsg_mem_subbanked_rr_arbiter_pkg.sv
// Shared types and constants for the subbanked memory round-robin arbiter.
package bsg_mem_subbanked_rr_arbiter_pkg;

    localparam int counter_width_lp = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INFLIGHT = 2'd1,
        HOLD     = 2'd2
    } resp_state_e;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_mem_subbanked_rr_resp_slot.sv
// Per-requester read-response slot: tracks one outstanding read, bypasses the
// memory output in the return cycle and holds it until the requester yumis.
module bsg_mem_subbanked_rr_resp_slot
    import bsg_mem_subbanked_rr_arbiter_pkg::*;
#(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               accept_read_i,
    input  logic               yumi_i,
    input  logic [width_p-1:0] mem_data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               idle_o
);

    resp_state_e        state_reg, state_next;
    logic [width_p-1:0] data_reg;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= IDLE;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            // Memory output is only valid for one cycle, so capture it now.
            if (state_reg == INFLIGHT)
                data_reg <= mem_data_i;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:     if (accept_read_i) state_next = INFLIGHT;
            INFLIGHT: state_next = yumi_i ? IDLE : HOLD;
            HOLD:     if (yumi_i) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    assign v_o    = (state_reg != IDLE);
    assign idle_o = (state_reg == IDLE);
    assign data_o = (state_reg == INFLIGHT) ? mem_data_i : data_reg;

    assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
        else $error("yumi_i asserted without v_o");

endmodule

// File: rtl/bsg_mem_subbanked_rr_arbiter.sv
// Round-robin arbiter sharing one subbanked byte-masked SRAM between requesters.
// Optional statistics counters: define BSG_MEM_SUBBANKED_RR_ARBITER_STATS_EN.
module bsg_mem_subbanked_rr_arbiter
    import bsg_mem_subbanked_rr_arbiter_pkg::*;
#(
    parameter int width_p       = 64,
    parameter int els_p         = 512,
    parameter int num_subbank_p = 2,
    parameter int num_req_p     = 2,
    localparam int subbank_width_lp = width_p / num_subbank_p,
    localparam int mask_width_lp    = subbank_width_lp / 8,
    localparam int lg_els_lp        = safe_clog2(els_p)
) (
    input  logic                                                  clk_i,
    input  logic                                                  reset_n_i,
    input  logic [num_req_p-1:0]                                  v_i,
    input  logic [num_req_p-1:0]                                  w_i,
    input  logic [num_req_p-1:0][num_subbank_p-1:0]               subbank_v_i,
    input  logic [num_req_p-1:0][lg_els_lp-1:0]                   addr_i,
    input  logic [num_req_p-1:0][width_p-1:0]                     data_i,
    input  logic [num_req_p-1:0][num_subbank_p-1:0][mask_width_lp-1:0] w_mask_i,
    output logic [num_req_p-1:0]                                  ready_o,
    output logic [num_req_p-1:0]                                  v_o,
    output logic [num_req_p-1:0][width_p-1:0]                     data_o,
    input  logic [num_req_p-1:0]                                  yumi_i,
    output logic [num_subbank_p-1:0]                              mem_v_o,
    output logic                                                  mem_w_o,
    output logic [lg_els_lp-1:0]                                  mem_addr_o,
    output logic [width_p-1:0]                                    mem_data_o,
    output logic [num_subbank_p-1:0][mask_width_lp-1:0]           mem_w_mask_o,
    input  logic [width_p-1:0]                                    mem_data_i
`ifdef BSG_MEM_SUBBANKED_RR_ARBITER_STATS_EN
    ,
    output logic [num_req_p-1:0][counter_width_lp-1:0]            grant_cnt_o,
    output logic [counter_width_lp-1:0]                           conflict_cnt_o
`endif
);

    localparam int lg_req_lp = safe_clog2(num_req_p);

    logic [num_req_p-1:0] slot_idle;
    logic [num_req_p-1:0] eligible;
    logic [num_req_p-1:0] grant;
    logic [lg_req_lp-1:0] grant_idx;
    logic [lg_req_lp-1:0] cand_idx;
    logic                 grant_found;
    logic [lg_req_lp-1:0] last_grant_reg;

    assign eligible = v_i & slot_idle;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        cand_idx    = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= num_req_p; k++) begin
            cand_idx = lg_req_lp'((int'(last_grant_reg) + k) % num_req_p);
            if (!grant_found && eligible[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                grant_found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            last_grant_reg <= lg_req_lp'(num_req_p - 1);
        else if (grant_found)
            last_grant_reg <= grant_idx;
    end

    assign ready_o    = grant;
    assign mem_v_o    = grant_found ? subbank_v_i[grant_idx] : '0;
    assign mem_w_o    = w_i[grant_idx];
    assign mem_addr_o = addr_i[grant_idx];
    assign mem_data_o = data_i[grant_idx];

    generate
        for (genvar gi = 0; gi < num_subbank_p; gi++) begin : g_mask
            assign mem_w_mask_o[gi] = (grant_found && subbank_v_i[grant_idx][gi])
                                    ? w_mask_i[grant_idx][gi] : '0;
        end

        for (genvar gi = 0; gi < num_req_p; gi++) begin : g_slot
            bsg_mem_subbanked_rr_resp_slot #(
                .width_p (width_p)
            ) slot (
                .clk_i         (clk_i),
                .reset_n_i     (reset_n_i),
                .accept_read_i (grant[gi] & ~w_i[gi]),
                .yumi_i        (yumi_i[gi]),
                .mem_data_i    (mem_data_i),
                .v_o           (v_o[gi]),
                .data_o        (data_o[gi]),
                .idle_o        (slot_idle[gi])
            );
        end
    endgenerate

`ifdef BSG_MEM_SUBBANKED_RR_ARBITER_STATS_EN
    logic [num_req_p-1:0][counter_width_lp-1:0] grant_cnt_reg;
    logic [counter_width_lp-1:0]                conflict_cnt_reg;

    generate
        for (genvar gi = 0; gi < num_req_p; gi++) begin : g_grant_cnt
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i)
                    grant_cnt_reg[gi] <= '0;
                else if (grant[gi] && (grant_cnt_reg[gi] != '1))
                    grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            conflict_cnt_reg <= '0;
        else if (($countones(eligible) > 1) && (conflict_cnt_reg != '1))
            conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
    end

    assign grant_cnt_o    = grant_cnt_reg;
    assign conflict_cnt_o = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_bsg_mem_subbanked_rr_arbiter.sv
// Directed bench for bsg_mem_subbanked_rr_arbiter with a behavioural byte-masked SRAM.
module tb_bsg_mem_subbanked_rr_arbiter;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        v, w, yumi;
    logic [1:0][1:0]   subbank_v;
    logic [1:0][8:0]   addr;
    logic [1:0][63:0]  data;
    logic [1:0][1:0][3:0] w_mask;
    logic [1:0]        ready_o, v_o;
    logic [1:0][63:0]  data_o;
    logic [1:0]        mem_v_o;
    logic              mem_w_o;
    logic [8:0]        mem_addr_o;
    logic [63:0]       mem_data_o;
    logic [1:0][3:0]   mem_w_mask_o;
    logic [63:0]       mem_data_i;
`ifdef BSG_MEM_SUBBANKED_RR_ARBITER_STATS_EN
    logic [1:0][31:0]  grant_cnt_o;
    logic [31:0]       conflict_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_mem_subbanked_rr_arbiter #(
        .width_p(64), .els_p(512), .num_subbank_p(2), .num_req_p(2)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .v_i          (v),
        .w_i          (w),
        .subbank_v_i  (subbank_v),
        .addr_i       (addr),
        .data_i       (data),
        .w_mask_i     (w_mask),
        .ready_o      (ready_o),
        .v_o          (v_o),
        .data_o       (data_o),
        .yumi_i       (yumi),
        .mem_v_o      (mem_v_o),
        .mem_w_o      (mem_w_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_w_mask_o (mem_w_mask_o),
        .mem_data_i   (mem_data_i)
`ifdef BSG_MEM_SUBBANKED_RR_ARBITER_STATS_EN
        ,
        .grant_cnt_o    (grant_cnt_o),
        .conflict_cnt_o (conflict_cnt_o)
`endif
    );

    // SRAM model: read data appears for exactly one cycle, garbage otherwise.
    logic [63:0] mem [512];
    logic [7:0]  mask_flat;
    assign mask_flat = mem_w_mask_o;

    initial for (int i = 0; i < 512; i++) mem[i] = '0;

    always @(posedge clk) begin
        if ((|mem_v_o) && mem_w_o)
            for (int b = 0; b < 8; b++)
                if (mask_flat[b]) mem[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
        mem_data_i <= ((|mem_v_o) && !mem_w_o) ? mem[mem_addr_o] : {$urandom, $urandom};
    end

    always @(posedge clk)
        if (reset_n && (|ready_o))
            $display("txn: ready=%b w=%b mem_addr=%0d mem_v=%b mask=%h", ready_o,
                     mem_w_o, mem_addr_o, mem_v_o, mask_flat);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; v = '0; w = '0; yumi = '0;
        subbank_v = '0; addr = '0; data = '0; w_mask = '0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_v_o", 64'(v_o), 64'h0);
        check("rst_ready", 64'(ready_o), 64'h0);
        check("rst_mem_v", 64'(mem_v_o), 64'h0);
        check("rst_data0", data_o[0], 64'h0);
        check("rst_data1", data_o[1], 64'h0);

        // Full write then readback by requester 0
        @(negedge clk); reset_n = 1'b1;
        v = 2'b01; w = 2'b01; addr[0] = 9'd5; data[0] = 64'hAABB_CCDD_EEFF_0011;
        subbank_v[0] = 2'b11; w_mask[0] = 8'hFF;
        #2;
        check("wr_ready", 64'(ready_o), 64'h1);
        check("wr_mem_v", 64'(mem_v_o), 64'h3);
        check("wr_mem_w", 64'(mem_w_o), 64'h1);
        check("wr_addr", 64'(mem_addr_o), 64'd5);
        check("wr_data", mem_data_o, 64'hAABB_CCDD_EEFF_0011);
        check("wr_mask", 64'(mem_w_mask_o), 64'hFF);
        @(negedge clk); w = 2'b00;
        #2;
        check("rd_ready", 64'(ready_o), 64'h1);
        check("rd_mem_w", 64'(mem_w_o), 64'h0);
        @(negedge clk); v = 2'b00; yumi = 2'b01;
        #2;
        check("rd_v_o", 64'(v_o), 64'h1);
        check("rd_data", data_o[0], 64'hAABB_CCDD_EEFF_0011);
        @(negedge clk); yumi = 2'b00;
        #2;
        check("rd_done_v_o", 64'(v_o), 64'h0);

        // Both requesters writing: last winner was 0, so 1,0,1,0,...
        @(negedge clk);
        v = 2'b11; w = 2'b11; addr[0] = 9'd20; addr[1] = 9'd30;
        data[1] = 64'h0123_4567_89AB_CDEF; subbank_v[1] = 2'b11; w_mask[1] = 8'hFF;
        for (int c = 0; c < 6; c++) begin
            #2;
            check("alt_ready", 64'(ready_o), (c % 2 == 0) ? 64'h2 : 64'h1);
            check("alt_addr", 64'(mem_addr_o), (c % 2 == 0) ? 64'd30 : 64'd20);
            @(negedge clk);
        end
        v = 2'b00;

        // Requester 1 read held for 5 cycles while it keeps requesting
        @(negedge clk); v = 2'b10; w = 2'b00; addr[1] = 9'd5;
        #2;
        check("hold_accept", 64'(ready_o), 64'h2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #2;
            check("hold_v_o1", 64'(v_o[1]), 64'h1);
            check("hold_data1", data_o[1], 64'hAABB_CCDD_EEFF_0011);
            check("hold_ready", 64'(ready_o), 64'h0);
        end
        @(negedge clk); yumi = 2'b10;
        #2;
        check("hold_yumi_ready", 64'(ready_o), 64'h0);
        @(negedge clk); yumi = 2'b00;
        #2;
        check("reissue_ready", 64'(ready_o), 64'h2);
        @(negedge clk); v = 2'b00; yumi = 2'b10;
        #2;
        check("reissue_data", data_o[1], 64'hAABB_CCDD_EEFF_0011);
        @(negedge clk); yumi = 2'b00;

        // Partial write: only subbank 0 touched, subbank 1 mask must be gated
        @(negedge clk);
        v = 2'b01; w = 2'b01; addr[0] = 9'd7; data[0] = 64'h1122_3344_5566_7788;
        subbank_v[0] = 2'b01; w_mask[0] = 8'hFF;
        #2;
        check("part_mask", 64'(mem_w_mask_o), 64'h0F);
        check("part_mem_v", 64'(mem_v_o), 64'h1);
        @(negedge clk); w = 2'b00; subbank_v[0] = 2'b11;
        #2;
        check("part_rd_ready", 64'(ready_o), 64'h1);
        @(negedge clk); v = 2'b00; yumi = 2'b01;
        #2;
        check("part_rd_data", data_o[0], 64'h0000_0000_5566_7788);
        @(negedge clk); yumi = 2'b00;

        // Reset during an outstanding read
        @(negedge clk); v = 2'b01; w = 2'b00; addr[0] = 9'd5;
        #2;
        check("mid_accept", 64'(ready_o), 64'h1);
        @(negedge clk); v = 2'b00;
        #2;
        check("mid_inflight", 64'(v_o), 64'h1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_v_o", 64'(v_o), 64'h0);
        check("mid_rst_data", data_o[0], 64'h0);
        @(negedge clk); reset_n = 1'b1; v = 2'b11; w = 2'b11;
        #2;
        check("post_rst_first", 64'(ready_o), 64'h1);
        @(negedge clk); v = 2'b00;

`ifdef BSG_MEM_SUBBANKED_RR_ARBITER_STATS_EN
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1; v = 2'b11; w = 2'b11;
        for (int c = 0; c < 10; c++) begin
            #2;
            @(negedge clk);
        end
        v = 2'b00;
        #2;
        check("conflict_cnt", 64'(conflict_cnt_o), 64'd10);
        check("grant_cnt0", 64'(grant_cnt_o[0]), 64'd5);
        check("grant_cnt1", 64'(grant_cnt_o[1]), 64'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
